seg_digit_driver: RTL and testbench

Segment-data stage that sits directly downstream of the display scanner and shares its digit-select bus. It uses the scanner's 3-bit `sel` to pick one nibble of a 32-bit display word, decodes the nibble to a 7-segment pattern plus decimal point, and registers the result so `seg` lines up with the scanner's `ds`. New display words arrive over a valid/ready handshake and take effect only at a frame boundary, so a frame never shows a mix of old and new digits.

---
 rtl/seg_digit_driver.sv | 150 +++++++++++++++
 tb/tb_seg_digit_driver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seg_digit_driver.sv
// Segment-data stage behind the display scanner: picks a nibble by `sel`, decodes it to
// 7-seg + dp, registers it to line up with `ds`. Optional blink via `define SEG_BLINK_EN.
module seg_digit_driver #(
   parameter bit LZ_BLANK       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter int BLINK_DIV      = 22
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic [2:0]  sel,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic        data_valid,
   output logic        data_ready,
   input  logic [7:0]  blink_mask,
   output logic [7:0]  seg,
   output logic        frame_start
);

   // Handshake: a word moves when data_valid && data_ready at a rising edge;
   // data_ready depends only on the pending flag, and the source must hold
   // data_valid/data_in/dp_in steady until it sees the transfer.

   logic [2:0]  sel_q;
   logic        frame_start_q, frame_start_d;
   logic [31:0] pend_word_q, pend_word_d;
   logic [7:0]  pend_dp_q, pend_dp_d;
   logic        pend_full_q, pend_full_d;
   logic [31:0] act_word_q, act_word_d;
   logic [7:0]  act_dp_q, act_dp_d;
   logic [7:0]  seg_q, seg_d;

   logic        boundary;
   logic        xfer;
   logic        commit;
   logic [3:0]  nibble;
   logic        dp_bit;
   logic [7:0]  lz_blank;
   logic        blink_off;
   logic [7:0]  pattern;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign boundary   = (sel == 3'd0) && (sel_q == 3'd7);
   assign data_ready = ~pend_full_q;
   assign xfer       = data_valid & ~pend_full_q;
   assign commit     = boundary & pend_full_q;

   always_comb begin
      pend_word_d   = pend_word_q;
      pend_dp_d     = pend_dp_q;
      pend_full_d   = pend_full_q;
      act_word_d    = act_word_q;
      act_dp_d      = act_dp_q;
      frame_start_d = boundary;
      if (xfer) begin
         pend_word_d = data_in;
         pend_dp_d   = dp_in;
         pend_full_d = 1'b1;
      end else if (commit) begin
         act_word_d  = pend_word_q;
         act_dp_d    = pend_dp_q;
         pend_full_d = 1'b0;
      end
   end

   // Decode from the next-active word so the boundary edge already shows the new digit 0.
   always_comb begin
      nibble      = act_word_d[{sel, 2'b00} +: 4];
      dp_bit      = act_dp_d[sel];
      lz_blank    = 8'h00;
      lz_blank[7] = (act_word_d[31:28] == 4'h0);
      for (int i = 6; i >= 1; i--) begin
         lz_blank[i] = lz_blank[i+1] & (act_word_d[4*i +: 4] == 4'h0);
      end
   end

`ifdef SEG_BLINK_EN
   logic [BLINK_DIV:0] blink_cnt_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
      end else begin
         blink_cnt_q <= blink_cnt_q + {{BLINK_DIV{1'b0}}, 1'b1};
      end
   end

   assign blink_off = blink_cnt_q[BLINK_DIV] & blink_mask[sel];
`else
   logic unused_blink;
   assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
   assign blink_off    = 1'b0;
`endif

   always_comb begin
      pattern = {dp_bit, hex_to_seg(nibble)};
      if ((LZ_BLANK && lz_blank[sel]) || blink_off) begin
         pattern = 8'h00;
      end
      seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         sel_q         <= 3'd0;
         frame_start_q <= 1'b0;
         pend_word_q   <= 32'h0;
         pend_dp_q     <= 8'h00;
         pend_full_q   <= 1'b0;
         act_word_q    <= 32'h0;
         act_dp_q      <= 8'h00;
         seg_q         <= {8{SEG_ACTIVE_LOW}};
      end else begin
         sel_q         <= sel;
         frame_start_q <= frame_start_d;
         pend_word_q   <= pend_word_d;
         pend_dp_q     <= pend_dp_d;
         pend_full_q   <= pend_full_d;
         act_word_q    <= act_word_d;
         act_dp_q      <= act_dp_d;
         seg_q         <= seg_d;
      end
   end

   assign seg         = seg_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_digit_driver.sv
// Bench for seg_digit_driver: default build plus a LZ_BLANK=0 / SEG_ACTIVE_LOW=1 copy on the
// same inputs; directed sel/word sequences with hand-computed patterns fed to a scoreboard.
module tb_seg_digit_driver;

   logic        clock;
   logic        rst_n;
   logic [2:0]  sel;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic        data_valid;
   logic [7:0]  blink_mask;
   logic        data_ready, data_ready2;
   logic [7:0]  seg, seg2;
   logic        frame_start, frame_start2;

   logic [31:0] nxt_d;
   logic [7:0]  nxt_dp;

   // {seg (default), seg (inverted, no blanking), ready, frame_start}
   logic [17:0] exp_q[$];
   int          n_chk;
   int          n_pass;
   int          step_no;

   seg_digit_driver dut (
      .clock(clock), .rst_n(rst_n), .sel(sel), .data_in(data_in), .dp_in(dp_in),
      .data_valid(data_valid), .data_ready(data_ready), .blink_mask(blink_mask),
      .seg(seg), .frame_start(frame_start)
   );

   seg_digit_driver #(.LZ_BLANK(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_inv (
      .clock(clock), .rst_n(rst_n), .sel(sel), .data_in(data_in), .dp_in(dp_in),
      .data_valid(data_valid), .data_ready(data_ready2), .blink_mask(blink_mask),
      .seg(seg2), .frame_start(frame_start2)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic step(input logic [2:0] s, input logic v, input logic [7:0] e1,
                       input logic [7:0] e2, input logic rdy, input logic fs);
      @(negedge clock);
      rst_n      = 1'b1;
      sel        = s;
      data_valid = v;
      data_in    = nxt_d;
      dp_in      = nxt_dp;
      exp_q.push_back({e1, e2, rdy, fs});
   endtask

   task automatic rst_step();
      @(negedge clock);
      rst_n      = 1'b0;
      sel        = 3'd0;
      data_valid = 1'b0;
      exp_q.push_back({8'h00, 8'hFF, 1'b1, 1'b0});
   endtask

   // Monitor: one expected entry per driven cycle, compared just after the edge.
   initial begin
      logic [17:0] e;
      logic [19:0] act, want;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            act  = {seg, seg2, data_ready, frame_start, data_ready2, frame_start2};
            want = {e, e[1:0]};
            n_chk++;
            step_no++;
            if (act === want) n_pass++;
            else $display("FAIL step%0d sel=%0d: got seg=%h seg_inv=%h rdy=%b fs=%b rdy_inv=%b fs_inv=%b, want seg=%h seg_inv=%h rdy=%b fs=%b",
                          step_no, sel, act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                          e[17:10], e[9:2], e[1], e[0]);
         end
      end
   end

   initial begin
      n_chk = 0; n_pass = 0; step_no = 0;
      rst_n = 1'b0; sel = 3'd0; data_in = 32'h0; dp_in = 8'h00; data_valid = 1'b0;
      blink_mask = 8'hFF;
      nxt_d = 32'h0; nxt_dp = 8'h00;

      rst_step();
      // frame 1: only digit 0 lit, no boundary yet
      step(3'd0, 1'b0, 8'h3F, 8'hC0, 1'b1, 1'b0);
      for (int i = 1; i < 8; i++) step(i[2:0], 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0);
      // frame 2: word offered mid-frame, old word still shown
      step(3'd0, 1'b0, 8'h3F, 8'hC0, 1'b1, 1'b1);
      step(3'd1, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0);
      step(3'd2, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0);
      nxt_d = 32'h1234ABCD; nxt_dp = 8'h01;
      step(3'd3, 1'b1, 8'h00, 8'hC0, 1'b0, 1'b0);
      for (int i = 4; i < 8; i++) step(i[2:0], 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0);
      // frame 3: 1234ABCD shown; word A accepted, word B held off
      step(3'd0, 1'b0, 8'hDE, 8'h21, 1'b1, 1'b1);
      nxt_d = 32'h00000500; nxt_dp = 8'h00;
      step(3'd1, 1'b1, 8'h39, 8'hC6, 1'b0, 1'b0);
      nxt_d = 32'h00000008; nxt_dp = 8'h00;
      step(3'd2, 1'b1, 8'h7C, 8'h83, 1'b0, 1'b0);
      step(3'd3, 1'b1, 8'h77, 8'h88, 1'b0, 1'b0);
      step(3'd4, 1'b1, 8'h66, 8'h99, 1'b0, 1'b0);
      step(3'd5, 1'b1, 8'h4F, 8'hB0, 1'b0, 1'b0);
      step(3'd6, 1'b1, 8'h5B, 8'hA4, 1'b0, 1'b0);
      step(3'd7, 1'b1, 8'h06, 8'hF9, 1'b0, 1'b0);
      // frame 4: A commits; B accepted on the following edge
      step(3'd0, 1'b1, 8'h3F, 8'hC0, 1'b1, 1'b1);
      step(3'd1, 1'b1, 8'h3F, 8'hC0, 1'b0, 1'b0);
      step(3'd2, 1'b0, 8'h6D, 8'h92, 1'b0, 1'b0);
      for (int i = 3; i < 8; i++) step(i[2:0], 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0);
      // frame 5: B commits; then sel jumps, 5->0 is not a boundary
      step(3'd0, 1'b0, 8'h7F, 8'h80, 1'b1, 1'b1);
      for (int i = 1; i < 7; i++) step(i[2:0], 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0);
      nxt_d = 32'hFFFFFFFF; nxt_dp = 8'hFF;
      step(3'd5, 1'b1, 8'h00, 8'hC0, 1'b0, 1'b0);
      step(3'd0, 1'b0, 8'h7F, 8'h80, 1'b0, 1'b0);
      step(3'd7, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0);
      step(3'd0, 1'b0, 8'hF1, 8'h0E, 1'b1, 1'b1);
      step(3'd3, 1'b0, 8'hF1, 8'h0E, 1'b1, 1'b0);
      // reset with a word pending: both pending and active are dropped
      nxt_d = 32'h87654321; nxt_dp = 8'h00;
      step(3'd4, 1'b1, 8'hF1, 8'h0E, 1'b0, 1'b0);
      rst_step();
      step(3'd0, 1'b0, 8'h3F, 8'hC0, 1'b1, 1'b0);
      step(3'd7, 1'b0, 8'h00, 8'hC0, 1'b1, 1'b0);
      step(3'd0, 1'b0, 8'h3F, 8'hC0, 1'b1, 1'b1);
      // all-zero word with every dp set: blanked digits lose their dp too
      nxt_d = 32'h00000000; nxt_dp = 8'hFF;
      step(3'd1, 1'b1, 8'h00, 8'hC0, 1'b0, 1'b0);
      step(3'd7, 1'b0, 8'h00, 8'hC0, 1'b0, 1'b0);
      step(3'd0, 1'b0, 8'hBF, 8'h40, 1'b1, 1'b1);
      step(3'd1, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0);
      step(3'd2, 1'b0, 8'h00, 8'h40, 1'b1, 1'b0);

      repeat (4) @(posedge clock);
      #2;
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
